hi_mode_sequencer: RTL

//  Glitch-free scheduler for the HF modulation type driven into hi_iso14443a.

---
 rtl/hi_mode_sequencer_pkg.sv | 32 +++
 rtl/hi_mode_sequencer_quiet_timer.sv | 41 ++++
 rtl/hi_mode_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hi_mode_sequencer_pkg.sv
// Shared mode codes, FSM encodings and the pending-slot bundle
// for the HF mod_type sequencer.
package hi_mode_sequencer_pkg;

  localparam logic [2:0] MOD_SNIFFER     = 3'b000;
  localparam logic [2:0] MOD_FAKE_READER = 3'b101;
  localparam logic [2:0] MOD_FAKE_TAG    = 3'b110;
  localparam logic [2:0] MOD_RELAY_ANY   = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic SRC_ARM   = 1'b0;
  localparam logic SRC_RELAY = 1'b1;

  typedef struct packed {
    logic       v;
    logic       src;
    logic [2:0] mod;
  } pend_t;

  function automatic logic is_relay_mode(
    input logic [2:0] m
  );
    return (m == MOD_FAKE_READER)
        || (m == MOD_FAKE_TAG)
        || (m == MOD_RELAY_ANY);
  endfunction

endpackage

// File: rtl/hi_mode_sequencer_quiet_timer.sv
// Run-length counter: counts enabled, non-busy cycles and pulses done
// on the N-th one. Ports: clk_i, rst_ni, en_i, busy_i -> done_o.
module hi_mode_sequencer_quiet_timer #(
  parameter int CW = 13,
  parameter int N  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic busy_i,
  output logic done_o
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] MAXV = {CW{1'b1}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Restart on disable or busy; saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || busy_i) begin
      cnt_d = '0;
    end else if (cnt_q != MAXV) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && !busy_i
               && (cnt_q == LAST);

endmodule

// File: rtl/hi_mode_sequencer.sv
// Glitch-free mod_type scheduler: latches ARM/relay requests, applies
// them only after a quiet guard (or timeout), then holds a dwell.
// In: ck_1356meg, nreset, cfg_strobe/cfg_mod, relay_req/relay_mod,
//  mod_busy. Out: mod_type, relay_active, relay_grant,
//  switch_pending, timeout_flag.
module hi_mode_sequencer
  import hi_mode_sequencer_pkg::*;
#(
  parameter int GUARD_CYCLES = 16,
  parameter int MIN_DWELL    = 64,
  parameter int TIMEOUT      = 4096,
  parameter int CW           = 13
) (
  input  logic       ck_1356meg,
  input  logic       nreset,
  input  logic       cfg_strobe,
  input  logic [2:0] cfg_mod,
  input  logic       relay_req,
  input  logic [2:0] relay_mod,
  input  logic       mod_busy,
  output logic [2:0] mod_type,
  output logic       relay_active,
  output logic       relay_grant,
  output logic       switch_pending,
  output logic       timeout_flag
);

  logic [1:0] state_q, state_d;
  pend_t      pend_q, pend_d;
  logic [2:0] mod_q, mod_d;
  logic [2:0] arm_q, arm_d;
  logic       ract_q;
  logic       tflag_q, tflag_d;

  logic in_wait, in_apply, in_hold;
  logic q_done, t_done, d_done;
  logic forced;

  assign in_wait  = (state_q == ST_WAIT);
  assign in_apply = (state_q == ST_APPLY);
  assign in_hold  = (state_q == ST_HOLD);

  hi_mode_sequencer_quiet_timer #(
    .CW (CW),
    .N  (GUARD_CYCLES)
  ) u_guard (
    .clk_i  (ck_1356meg),
    .rst_ni (nreset),
    .en_i   (in_wait),
    .busy_i (mod_busy),
    .done_o (q_done)
  );

  hi_mode_sequencer_quiet_timer #(
    .CW (CW),
    .N  (TIMEOUT)
  ) u_tmo (
    .clk_i  (ck_1356meg),
    .rst_ni (nreset),
    .en_i   (in_wait),
    .busy_i (1'b0),
    .done_o (t_done)
  );

  hi_mode_sequencer_quiet_timer #(
    .CW (CW),
    .N  (MIN_DWELL)
  ) u_dwell (
    .clk_i  (ck_1356meg),
    .rst_ni (nreset),
    .en_i   (in_hold),
    .busy_i (1'b0),
    .done_o (d_done)
  );

  // A clean guard on the same cycle as the timeout is not a forced switch.
  assign forced = in_wait && t_done && !q_done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pend_q.v) state_d = ST_WAIT;
      ST_WAIT:  if (q_done || t_done) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_HOLD;
      ST_HOLD:  if (d_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A new load in the APPLY cycle survives the slot release.
  always_comb begin
    pend_d = pend_q;
    if (in_apply) pend_d.v = 1'b0;
    if (cfg_strobe) begin
      pend_d = '{v: 1'b1, src: SRC_ARM, mod: cfg_mod};
    end else if (relay_req && ract_q && !pend_q.v) begin
      pend_d = '{v: 1'b1, src: SRC_RELAY, mod: relay_mod};
    end
  end

  always_comb begin
    mod_d = mod_q;
    arm_d = arm_q;
    if (in_apply) begin
      mod_d = pend_q.mod;
      if (pend_q.src == SRC_ARM) arm_d = pend_q.mod;
    end
  end

  always_comb begin
    tflag_d = tflag_q;
    if (forced) begin
      tflag_d = 1'b1;
    end else if (cfg_strobe) begin
      tflag_d = 1'b0;
    end
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      mod_q   <= MOD_SNIFFER;
      arm_q   <= MOD_SNIFFER;
      ract_q  <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mod_q   <= mod_d;
      arm_q   <= arm_d;
      ract_q  <= is_relay_mode(arm_q);
      tflag_q <= tflag_d;
    end
  end

  assign mod_type       = mod_q;
  assign relay_active   = ract_q;
  assign switch_pending = pend_q.v;
  assign timeout_flag   = tflag_q;
  assign relay_grant    = in_apply
                       && (pend_q.src == SRC_RELAY);

endmodule
